// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event queue.
// Contains the decoder state enum, the event record and the prefix byte values.
package kbd_pkg;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK = 8'hF0;
  localparam logic [7:0] KBD_NULL    = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO with power-of-two depth.
// The pointers carry one extra wrap bit, so full and empty are told apart without a counter.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  kbd_evt_t               i_data,
  input  logic                   i_pop,
  output kbd_evt_t               o_head,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  kbd_evt_t    r_mem [DEPTH];

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible until the write pointer moves.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_valid = ~w_empty;
  assign o_fill  = r_wr - r_rd;

endmodule

// File: rtl/kbd_evt_queue.sv
// PS/2 scancode decoder feeding an event FIFO, with press statistics and key-held tracking.
// Optional macro KBD_REPEAT_FILTER_EN drops typematic repeats of the held key.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
module kbd_evt_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_ovf,
  output logic                   in_ack,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_code,
  output logic                   evt_ext,
  output logic                   evt_break,
  output logic [$clog2(DEPTH):0] fill,
  output logic [CNT_W-1:0]       press_cnt,
  output logic                   key_down,
  output logic [8:0]             last_key,
  output logic                   ovf_seen
);

  kbd_state_e       r_state;
  kbd_state_e       w_state_nxt;
  logic             r_ack;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_key_down;
  logic [8:0]       r_last_key;
  logic             r_ovf_seen;

  logic     w_full;
  logic     w_take;
  logic     w_emit;
  logic     w_repeat;
  logic     w_push;
  logic     w_match;
  kbd_evt_t w_evt;
  kbd_evt_t w_head;

  // A byte is taken only when the previous ack has retired and there is room.
  assign w_take = in_valid & ~r_ack & ~w_full;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_evt.ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    w_evt.brk   = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    w_evt.code  = in_data;
    if (w_take) begin
      if (r_state == ST_IDLE && in_data == KBD_PFX_EXT) begin
        w_state_nxt = ST_EXT;
      end else if (r_state == ST_IDLE && in_data == KBD_PFX_BRK) begin
        w_state_nxt = ST_BRK;
      end else if (r_state == ST_EXT && in_data == KBD_PFX_BRK) begin
        w_state_nxt = ST_EXT_BRK;
      end else begin
        w_state_nxt = ST_IDLE;
        w_emit      = (in_data != KBD_NULL);
      end
    end
  end

  assign w_match = ({w_evt.ext, w_evt.code} == r_last_key);

`ifdef KBD_REPEAT_FILTER_EN
  assign w_repeat = ~w_evt.brk & r_key_down & w_match;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_push = w_emit & ~w_repeat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack       <= 1'b0;
      r_press_cnt <= '0;
      r_key_down  <= 1'b0;
      r_last_key  <= '0;
      r_ovf_seen  <= 1'b0;
    end else begin
      r_ack <= w_take;
      if (in_ovf) r_ovf_seen <= 1'b1;
      if (w_push && !w_evt.brk) begin
        r_last_key  <= {w_evt.ext, w_evt.code};
        r_key_down  <= 1'b1;
        r_press_cnt <= r_press_cnt + CNT_W'(1);
      end else if (w_push && w_evt.brk && w_match) begin
        r_key_down <= 1'b0;
      end
    end
  end

  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (evt_ready),
    .o_head  (w_head),
    .o_valid (evt_valid),
    .o_full  (w_full),
    .o_fill  (fill)
  );

  assign in_ack    = r_ack;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;
  assign press_cnt = r_press_cnt;
  assign key_down  = r_key_down;
  assign last_key  = r_last_key;
  assign ovf_seen  = r_ovf_seen;

endmodule

// File: tb/tb_kbd_evt_queue.sv
// Self-checking bench for kbd_evt_queue: expected events go into a scoreboard queue
// as bytes are driven and are compared when the consumer accepts the FIFO head.
module tb_kbd_evt_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef KBD_REPEAT_FILTER_EN
  localparam int EXP_REP = 1;
`else
  localparam int EXP_REP = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ovf = 1'b0;
  logic       in_ack;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [$clog2(DEPTH):0] fill;
  logic [CNT_W-1:0] press_cnt;
  logic       key_down;
  logic [8:0] last_key;
  logic       ovf_seen;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb[$];

  kbd_evt_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ovf(in_ovf),
    .in_ack(in_ack), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .fill(fill),
    .press_cnt(press_cnt), .key_down(key_down), .last_key(last_key), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL evt_unexpected: got {ext,brk,code}=%03h, scoreboard empty",
                 {evt_ext, evt_break, evt_code});
      end else begin
        logic [9:0] exp_evt;
        exp_evt = sb.pop_front();
        if ({evt_ext, evt_break, evt_code} !== exp_evt) begin
          n_fail++;
          $display("FAIL evt_head: got %03h, expected %03h", {evt_ext, evt_break, evt_code}, exp_evt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (in_ack) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: byte %02h never acked", b);
    end
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !evt_valid) break;
      tick();
    end
    n_tests++;
    if (sb.size() != 0 || evt_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events still expected, evt_valid=%0b", name, sb.size(), evt_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 7;
    if (fill !== 0)      begin n_fail++; $display("FAIL rst_fill: got %0d, expected 0", fill); end
    if (evt_valid !== 0) begin n_fail++; $display("FAIL rst_evt_valid: got %0b, expected 0", evt_valid); end
    if (in_ack !== 0)    begin n_fail++; $display("FAIL rst_in_ack: got %0b, expected 0", in_ack); end
    if (press_cnt !== 0) begin n_fail++; $display("FAIL rst_press_cnt: got %0d, expected 0", press_cnt); end
    if (key_down !== 0)  begin n_fail++; $display("FAIL rst_key_down: got %0b, expected 0", key_down); end
    if (last_key !== 0)  begin n_fail++; $display("FAIL rst_last_key: got %03h, expected 000", last_key); end
    if (ovf_seen !== 0)  begin n_fail++; $display("FAIL rst_ovf_seen: got %0b, expected 0", ovf_seen); end
  endtask

  task automatic test_make_break();
    evt_ready = 1'b1;
    send_byte(8'h1C);
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'hF0);
    sb.push_back({2'b01, 8'h1C});
    send_byte(8'h1C);
    drain("make_break");
    n_tests += 3;
    if (press_cnt !== 1)     begin n_fail++; $display("FAIL mb_press_cnt: got %0d, expected 1", press_cnt); end
    if (key_down !== 0)      begin n_fail++; $display("FAIL mb_key_down: got %0b, expected 0", key_down); end
    if (last_key !== 9'h01C) begin n_fail++; $display("FAIL mb_last_key: got %03h, expected 01C", last_key); end
  endtask

  task automatic test_ext();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    sb.push_back({2'b10, 8'h75});
    send_byte(8'h75);
    n_tests++;
    if (key_down !== 1) begin n_fail++; $display("FAIL ext_key_held: got %0b, expected 1", key_down); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    sb.push_back({2'b11, 8'h75});
    send_byte(8'h75);
    drain("ext");
    n_tests += 3;
    if (last_key !== 9'h175) begin n_fail++; $display("FAIL ext_last_key: got %03h, expected 175", last_key); end
    if (press_cnt !== 2)     begin n_fail++; $display("FAIL ext_press_cnt: got %0d, expected 2", press_cnt); end
    if (key_down !== 0)      begin n_fail++; $display("FAIL ext_key_down: got %0b, expected 0", key_down); end
  endtask

  task automatic test_null_byte();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h00);
    sb.push_back({2'b00, 8'h2A});
    send_byte(8'h2A);
    drain("null");
    n_tests++;
    if (last_key !== 9'h02A) begin n_fail++; $display("FAIL null_last_key: got %03h, expected 02A", last_key); end
  endtask

  task automatic test_repeat();
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < EXP_REP) sb.push_back({2'b00, 8'h1C});
      send_byte(8'h1C);
    end
    drain("repeat");
    n_tests += 2;
    if (press_cnt !== CNT_W'(EXP_REP)) begin n_fail++; $display("FAIL rep_press_cnt: got %0d, expected %0d", press_cnt, EXP_REP); end
    if (key_down !== 1) begin n_fail++; $display("FAIL rep_key_down: got %0b, expected 1", key_down); end
  endtask

  task automatic test_full();
    bit saw_ack;
    bit got;
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back({2'b00, 8'(8'h10 + i)});
      send_byte(8'(8'h10 + i));
    end
    tick();
    n_tests++;
    if (fill !== DEPTH) begin n_fail++; $display("FAIL full_fill: got %0d, expected %0d", fill, DEPTH); end
    sb.push_back({2'b00, 8'h18});
    in_valid = 1'b1;
    in_data  = 8'h18;
    saw_ack  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (in_ack) saw_ack = 1'b1;
    end
    n_tests++;
    if (saw_ack) begin n_fail++; $display("FAIL full_no_ack: got ack=1 while full, expected 0"); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests += 2;
    if (fill !== DEPTH-1) begin n_fail++; $display("FAIL full_after_pop: got %0d, expected %0d", fill, DEPTH-1); end
    if (in_ack !== 0)     begin n_fail++; $display("FAIL full_ack_pop_edge: got %0b, expected 0", in_ack); end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (in_ack) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    n_tests += 2;
    if (!got)           begin n_fail++; $display("FAIL full_ninth_ack: got no ack, expected ack after pop"); end
    if (fill !== DEPTH) begin n_fail++; $display("FAIL full_refill: got %0d, expected %0d", fill, DEPTH); end
    drain("full");
    n_tests++;
    if (press_cnt !== 9) begin n_fail++; $display("FAIL full_press_cnt: got %0d, expected 9", press_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    tick();
    do_reset();
    sb.push_back({2'b00, 8'h1C});
    send_byte(8'h1C);
    drain("rst_mid");
    n_tests += 2;
    if (last_key !== 9'h01C) begin n_fail++; $display("FAIL rstmid_last_key: got %03h, expected 01C", last_key); end
    if (ovf_seen !== 0)      begin n_fail++; $display("FAIL rstmid_ovf_seen: got %0b, expected 0", ovf_seen); end
  endtask

  task automatic test_wrap_ovf();
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sb.push_back({2'b00, 8'h1C});
      send_byte(8'h1C);
      if (i == 254) begin
        n_tests++;
        if (press_cnt !== 8'hFF) begin n_fail++; $display("FAIL wrap_press_ff: got %0d, expected 255", press_cnt); end
      end
      send_byte(8'hF0);
      sb.push_back({2'b01, 8'h1C});
      send_byte(8'h1C);
    end
    drain("wrap");
    n_tests++;
    if (press_cnt !== 0) begin n_fail++; $display("FAIL wrap_press_0: got %0d, expected 0", press_cnt); end
    in_ovf = 1'b1;
    tick();
    in_ovf = 1'b0;
    n_tests++;
    if (ovf_seen !== 1) begin n_fail++; $display("FAIL ovf_set: got %0b, expected 1", ovf_seen); end
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (ovf_seen !== 1) begin n_fail++; $display("FAIL ovf_sticky: got %0b, expected 1", ovf_seen); end
    do_reset();
    n_tests++;
    if (ovf_seen !== 0) begin n_fail++; $display("FAIL ovf_rst: got %0b, expected 0", ovf_seen); end
  endtask

  initial begin
    tick();
    test_reset();
    test_make_break();
    test_ext();
    test_null_byte();
    test_repeat();
    test_full();
    test_reset_mid();
    test_wrap_ovf();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_evt_queue.md
KBD_EVT_QUEUE -- requirements
Module: kbd_evt_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth; a power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 8, width of press_cnt.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, the PS/2 receiver has a byte ready.
REQ-006 SHALL have port in_data, input, 8, the scancode byte from the receiver.
REQ-007 SHALL have port in_ovf, input, 1, the receiver overflow flag.
REQ-008 SHALL have port in_ack, output, 1, a one-cycle pulse that consumes the byte (drives the receiver's nextdata_n, inverted).
REQ-009 SHALL have port evt_valid, output, 1, the FIFO head is valid.
REQ-010 SHALL have port evt_ready, input, 1, the consumer accepts the head.
REQ-011 SHALL have port evt_code, output, 8, the head scancode.
REQ-012 SHALL have port evt_ext, output, 1, the head event was prefixed by E0.
REQ-013 SHALL have port evt_break, output, 1, the head event is a release.
REQ-014 SHALL have port fill, output, $clog2(DEPTH)+1, the FIFO occupancy.
REQ-015 SHALL have port press_cnt, output, CNT_W, the number of make events enqueued; it wraps.
REQ-016 SHALL have port key_down, output, 1, the last made key is still held.
REQ-017 SHALL have port last_key, output, 9, the {ext, code} of the last make event.
REQ-018 SHALL have port ovf_seen, output, 1, a sticky flag for in_ovf.

Function
REQ-019 SHALL consume a byte when in_valid=1, in_ack=0 and fill<DEPTH; in_ack=1 in the following cycle only.
REQ-020 SHALL NOT consume any byte while fill==DEPTH; in_ack stays 0 and the byte waits.
REQ-021 SHALL decode bytes with FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-022 SHALL apply these transitions: IDLE+E0 goes to EXT; IDLE+F0 goes to BRK; EXT+F0 goes to EXT_BRK; any other byte emits an event and returns to IDLE.
REQ-023 SHALL set event fields ext=(state in EXT or EXT_BRK) and break=(state in BRK or EXT_BRK).
REQ-024 SHALL consume byte 00 without emitting an event and return the FSM to IDLE.
REQ-025 SHALL write an emitted event into the FIFO on the edge that consumes its final byte, so evt_valid rises one cycle later.
REQ-026 SHALL pop the FIFO when evt_valid and evt_ready are both 1.
REQ-027 SHALL ignore evt_ready when the FIFO is empty.
REQ-028 SHALL leave fill unchanged on a simultaneous push and pop; pop at empty and push at full cannot occur.
REQ-029 SHALL drive evt_code, evt_ext and evt_break from the FIFO head; these are don't-care while evt_valid=0.
REQ-030 SHALL, on each enqueued make event, load last_key, set key_down=1 and increment press_cnt modulo 2^CNT_W.
REQ-031 SHALL clear key_down on a break event whose {ext, code} equals last_key; other breaks do not change key_down.
REQ-032 SHALL set ovf_seen on any cycle where in_ovf=1; only rst clears it.

Reset
REQ-033 SHALL, when rst=1 at a clock edge, force FSM=IDLE, FIFO empty (fill=0, evt_valid=0), in_ack=0, press_cnt=0, key_down=0, last_key=0 and ovf_seen=0.
REQ-034 SHALL, on reset mid-sequence (e.g. after E0), discard the partial prefix; the next byte decodes from IDLE.

Configuration
REQ-035 SHALL, with KBD_REPEAT_FILTER_EN defined, consume a make event whose {ext, code} equals last_key while key_down=1 but not enqueue or count it (typematic repeat suppression).
REQ-036 SHALL, without KBD_REPEAT_FILTER_EN, enqueue and count every make event.

Structure
REQ-037 SHALL take from package kbd_pkg: the FSM state enum, the event struct {ext, brk, code}, and constants KBD_PFX_EXT=8'hE0 and KBD_PFX_BRK=8'hF0.
REQ-038 SHALL implement the FIFO as sub-module kbd_evt_fifo (parameter DEPTH, synchronous, power-of-two pointers with a wrap bit).

Verification
REQ-039 SHALL cover: bytes 1C, F0, 1C, evt_ready=1 -> events {0,0,1C} then {0,1,1C}; press_cnt=1; key_down=0.
REQ-040 SHALL cover: bytes E0, 75, E0, F0, 75 -> events {1,0,75} then {1,1,75}; last_key=0x175.
REQ-041 SHALL cover: evt_ready=0, DEPTH=8, nine make bytes -> fill=8; the ninth byte is not acked until one pop, then it is acked and fill returns to 8.
REQ-042 SHALL cover: bytes 1C, 1C, 1C -> three events and press_cnt=3 without the macro; one event and press_cnt=1 with it.
REQ-043 SHALL cover: E0 then rst pulse then 1C -> single event {0,0,1C}; ovf_seen=0.
REQ-044 SHALL cover: CNT_W=8, 256 make/break pairs -> press_cnt wraps to 0; a one-cycle in_ovf pulse -> ovf_seen=1 until reset.
